// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: assembles WIDTH enabled samples of serial_in
// into a word and hands it to a single-entry output buffer with valid/ready.
module serial_word_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             dir,
  input  logic             serial_in,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic             dir_reg, dir_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;

  logic [WIDTH-1:0] shift_msb;
  logic [WIDTH-1:0] shift_lsb;
  logic [WIDTH-1:0] word;
  logic             sample;
  logic             done;

  // Both candidate shift results are built every cycle; dir_reg picks one.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_msb_in
        assign shift_msb[gi] = serial_in;
      end else begin : g_msb_sh
        assign shift_msb[gi] = sh_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_lsb_in
        assign shift_lsb[gi] = serial_in;
      end else begin : g_lsb_sh
        assign shift_lsb[gi] = sh_reg[gi+1];
      end
    end
  endgenerate

  assign word   = dir_reg ? shift_lsb : shift_msb;
  assign sample = (state_reg == RECV) && enable;
  assign done   = sample && (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sh_reg      <= '0;
      dir_reg     <= 1'b0;
      out_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sh_reg      <= sh_next;
      dir_reg     <= dir_next;
      out_reg     <= out_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sh_next    = sh_reg;
    dir_next   = dir_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RECV;
          cnt_next   = '0;
          sh_next    = '0;
          dir_next   = dir;
        end
      end
      RECV: begin
        if (enable) begin
          sh_next = word;
          if (done) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A completing word may replace the buffered one only if it is being consumed.
  always_comb begin
    out_next     = out_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (clr_ovr) begin
      overrun_next = 1'b0;
    end
    if (done) begin
      if (!valid_reg || ready) begin
        out_next   = word;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && ready) begin
      valid_next = 1'b0;
    end
  end

  assign out     = out_reg;
  assign valid   = valid_reg;
  assign busy    = (state_reg == RECV);
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed self-checking bench for serial_word_rx (WIDTH=4): framing, bit order,
// stalls, overrun, simultaneous consume/complete and asynchronous reset.
module tb_serial_word_rx;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       start;
  logic       dir;
  logic       serial_in;
  logic       ready;
  logic       clr_ovr;
  logic [3:0] out;
  logic       valid;
  logic       busy;
  logic       overrun;

  int checks;
  int errors;

  serial_word_rx #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .start    (start),
    .dir      (dir),
    .serial_in(serial_in),
    .ready    (ready),
    .clr_ovr  (clr_ovr),
    .out      (out),
    .valid    (valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full frame with enable held high; b[3] is sent first. ready/clr_ovr are
  // applied only on the final sample so the completion edge sees them.
  task automatic send_frame(input logic d, input logic [3:0] b,
                            input logic rdy_last, input logic clr_last);
    start = 1'b1;
    dir   = d;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable    = 1'b1;
      serial_in = b[3-i];
      if (i == 3) begin
        ready   = rdy_last;
        clr_ovr = clr_last;
      end
      step();
    end
    enable  = 1'b0;
    ready   = 1'b0;
    clr_ovr = 1'b0;
  endtask

  task automatic consume();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #2;
    checks++;
    if ({out, valid, busy, overrun} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_initial: got out=%b valid=%b busy=%b ovr=%b required 0000 0 0 0",
               out, valid, busy, overrun);
    end
    step();
    rst = 1'b1;
    step();
    // Fill buffer and raise overrun so that the mid-frame reset has state to clear.
    send_frame(1'b0, 4'b1010, 1'b0, 1'b0);
    send_frame(1'b0, 4'b0110, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || out !== 4'b1010) begin
      errors++;
      $display("FAIL reset_prefill: got out=%b ovr=%b required 1010 1", out, overrun);
    end
    start = 1'b1;
    dir   = 1'b0;
    step();
    start = 1'b0;
    enable = 1'b1;
    serial_in = 1'b1;
    step();
    serial_in = 1'b1;
    step();
    enable = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({out, valid, busy, overrun} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_midframe: got out=%b valid=%b busy=%b ovr=%b required 0000 0 0 0",
               out, valid, busy, overrun);
    end
    step();
    rst = 1'b1;
    step();
    send_frame(1'b0, 4'b1100, 1'b0, 1'b0);
    checks++;
    if (out !== 4'b1100 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_newframe: got out=%b valid=%b required 1100 1", out, valid);
    end
    consume();
    checks++;
    if (valid !== 1'b0 || out !== 4'b1100) begin
      errors++;
      $display("FAIL reset_consume: got valid=%b out=%b required 0 1100", valid, out);
    end
    $display("test_reset done: out=%b valid=%b", out, valid);
  endtask

  task automatic test_msb_first();
    logic [3:0] bits;
    bits  = 4'b1010;
    start = 1'b1;
    dir   = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL msb_busy_after_start: got busy=%b valid=%b required 1 0", busy, valid);
    end
    for (int i = 0; i < 4; i++) begin
      enable    = 1'b1;
      serial_in = bits[3-i];
      step();
      if (i == 2) begin
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL msb_early: got valid=%b busy=%b at edge 3 required 0 1", valid, busy);
        end
      end
    end
    enable = 1'b0;
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || out !== 4'b1010) begin
      errors++;
      $display("FAIL msb_complete: got out=%b valid=%b busy=%b required 1010 1 0",
               out, valid, busy);
    end
    consume();
    $display("test_msb_first done: out=%b", out);
  endtask

  task automatic test_lsb_first();
    logic [3:0] bits;
    bits  = 4'b0101;
    start = 1'b1;
    dir   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable    = 1'b1;
      serial_in = bits[3-i];
      if (i == 2) dir = 1'b0;
      step();
    end
    enable = 1'b0;
    checks++;
    if (out !== 4'b1010 || valid !== 1'b1) begin
      errors++;
      $display("FAIL lsb_dir_toggle: got out=%b valid=%b required 1010 1", out, valid);
    end
    consume();
    send_frame(1'b1, 4'b1000, 1'b0, 1'b0);
    checks++;
    if (out !== 4'b0001) begin
      errors++;
      $display("FAIL lsb_single_one: got out=%b required 0001", out);
    end
    consume();
    $display("test_lsb_first done: out=%b", out);
  endtask

  task automatic test_stall();
    logic [3:0] bits;
    bits  = 4'b1011;
    start = 1'b1;
    dir   = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      enable    = 1'b1;
      serial_in = bits[3-i];
      step();
    end
    enable    = 1'b0;
    serial_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    for (int i = 2; i < 4; i++) begin
      enable    = 1'b1;
      serial_in = bits[3-i];
      step();
      if (i == 2) begin
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL stall_not_done: got valid=%b busy=%b at edge 6 required 0 1",
                   valid, busy);
        end
      end
    end
    enable = 1'b0;
    checks++;
    if (out !== 4'b1011 || valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_complete: got out=%b valid=%b busy=%b at edge 7 required 1011 1 0",
               out, valid, busy);
    end
    consume();
    $display("test_stall done: out=%b", out);
  endtask

  task automatic test_overrun();
    send_frame(1'b0, 4'b1010, 1'b0, 1'b0);
    send_frame(1'b0, 4'b0110, 1'b0, 1'b0);
    checks++;
    if (out !== 4'b1010 || overrun !== 1'b1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got out=%b ovr=%b valid=%b required 1010 1 1", out, overrun, valid);
    end
    send_frame(1'b0, 4'b1111, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1 || out !== 4'b1010) begin
      errors++;
      $display("FAIL ovr_set_wins: got ovr=%b out=%b required 1 1010", overrun, out);
    end
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_clear: got ovr=%b valid=%b required 0 1", overrun, valid);
    end
    consume();
    checks++;
    if (valid !== 1'b0 || out !== 4'b1010) begin
      errors++;
      $display("FAIL ovr_consume: got valid=%b out=%b required 0 1010", valid, out);
    end
    $display("test_overrun done: out=%b ovr=%b", out, overrun);
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 4'b1010, 1'b0, 1'b0);
    send_frame(1'b0, 4'b0101, 1'b1, 1'b0);
    checks++;
    if (out !== 4'b0101 || valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul_replace: got out=%b valid=%b ovr=%b required 0101 1 0",
               out, valid, overrun);
    end
    consume();
    send_frame(1'b0, 4'b0011, 1'b0, 1'b0);
    checks++;
    if (out !== 4'b0011 || valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after_consume: got out=%b valid=%b ovr=%b required 0011 1 0",
               out, valid, overrun);
    end
    $display("test_back_to_back done: out=%b valid=%b", out, valid);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    enable    = 1'b0;
    start     = 1'b0;
    dir       = 1'b0;
    serial_in = 1'b0;
    ready     = 1'b0;
    clr_ovr   = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_overrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver that rebuilds words from the single-bit stream shifted out of the datapath shift register. It counts `WIDTH` enabled samples on `serial_in` for each frame. Completed words go into an output buffer with a valid/ready handshake. It is the receiving end of the shift-register serial link and feeds parallel consumers such as the register file or ALU operand latch.

## Interface
- `WIDTH`, 4: word width in bits; also the number of samples per frame (≥2).
- `clk`  input  1  system clock, all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `enable`  input  1  sample strobe; `serial_in` is taken only on edges where `enable`=1 and state is RECV.
- `start`  input  1  frame start request; honoured only in IDLE.
- `dir`  input  1  bit order: 0 = MSB first (matches shift-left source), 1 = LSB first (matches shift-right source); latched at start.
- `serial_in`  input  1  serial data bit.
- `ready`  input  1  consumer accepts `out` when `valid`&&`ready`.
- `clr_ovr`  input  1  synchronous clear of `overrun`.
- `out`  output  WIDTH  last completed word.
- `valid`  output  1  `out` holds an unconsumed word.
- `busy`  output  1  high while in RECV.
- `overrun`  output  1  sticky: a word completed while the buffer was still full.

## Operation
- States: IDLE, RECV. Internal regs: shift reg `sh[WIDTH-1:0]`, bit counter `cnt` ($clog2(WIDTH) bits), latched `dir_q`.
- IDLE: if `start`=1, go to RECV, `cnt`<=0, `sh`<=0, `dir_q`<=`dir`. Otherwise hold.
- RECV: if `enable`=0, all state holds (stall). If `enable`=1:
  - `dir_q`=0: `sh`<={`sh`[WIDTH-2:0], `serial_in`}.
  - `dir_q`=1: `sh`<={`serial_in`, `sh`[WIDTH-1:1]}.
  - `cnt`<=`cnt`+1.
- On the sample where `cnt`==WIDTH-1, the word is complete. The assembled word is the shifted value including this bit. Return to IDLE and set `cnt`<=0.
- `start` during RECV is ignored. `dir` changes during RECV have no effect.
- Buffer write on completion:
  - If `valid`=0: `out`<=word, `valid`<=1.
  - If `valid`=1 and `ready`=1 in the same cycle: the old word is consumed, `out`<=new word, `valid` stays 1, no overrun.
  - If `valid`=1 and `ready`=0: the new word is discarded, `out` keeps the old word, `overrun`<=1.
- Consumption without completion: `valid`&&`ready` sets `valid`<=0. `out` holds its last value.
- `overrun`: set as above, cleared by `clr_ovr`=1. If set and clear occur in the same cycle, set wins.
- `busy` = (state==RECV), registered state decode.
- Reset (async, any time, including mid-frame): state=IDLE, `cnt`=0, `sh`=0, `dir_q`=0, `out`=0, `valid`=0, `overrun`=0, `busy`=0. A partial frame is dropped.

## Timing
- `start` sampled at edge T0 → `busy`=1 after T0. The first bit can be sampled at T0+1.
- With `enable` held high, the bits are sampled at T0+1 … T0+WIDTH. After edge T0+WIDTH: `valid`=1, `out` updated, `busy`=0.
- Minimum frame-to-frame spacing: `start` may be asserted at the cycle right after completion (edge T0+WIDTH+1), giving WIDTH+1 cycles per word.
- Each low-`enable` cycle in RECV adds exactly one cycle of latency.
- The handshake is registered: `valid` falls on the edge where `valid`&&`ready`. There is no combinational path from `ready` to `valid`.

## Test plan
- Reset: drive `rst`=0 mid-RECV after 2 samples → immediately `out`=0000, `valid`=0, `busy`=0, `overrun`=0. After release, a full new frame of 1,1,0,0 (dir=0) → `out`=1100.
- MSB first: `start`, dir=0, enable=1, bits 1,0,1,0 → `valid`=1 and `out`=1010 exactly 4 edges after start, `busy` low at the same edge.
- LSB first: dir=1, bits 0,1,0,1 → `out`=1010. Toggling `dir` mid-frame leaves the result unchanged.
- Stall: dir=0, bits 1,0,1,1 with `enable`=0 for 3 cycles between bits 2 and 3 → `out`=1011, `valid` rises 3 cycles later than unstalled.
- Overrun: `ready`=0, two frames 1010 then 0110 → `out`=1010, `overrun`=1. Then `clr_ovr`=1 → `overrun`=0. Then `ready`=1 for one cycle → `valid`=0.
- Simultaneous: `valid`=1 with `out`=1010, and a frame 0101 completes on the same edge as `ready`=1 → `out`=0101, `valid`=1, `overrun`=0.
